seq_normalizer: RTL

SEQ_NORMALIZER -- requirements
Module: seq_normalizer

---
 rtl/seq_normalizer_pkg.sv | 25 ++
 rtl/seq_normalizer_stage.sv | 38 +++
 rtl/seq_normalizer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seq_normalizer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_normalizer_pkg
//  Purpose  : Shared types and constants for the sequential normalizer.
//             Holds the FSM state encoding, the operand width, the shift
//             amount width, and the number of binary-search stages.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seq_normalizer_pkg;

    localparam int DATA_W   = 32;
    localparam int AMT_W    = 5;
    localparam int N_STAGES = 5;
    // Stage counter runs N_STAGES-1 down to 0.
    localparam int CNT_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : seq_normalizer_pkg
`default_nettype wire

// File: rtl/seq_normalizer_stage.sv
`default_nettype none
// ============================================================================
//  Module   : normalize_stage
//  Purpose  : One combinational binary-search step of the normalizer. Tests
//             whether the working value can be shifted left by k without
//             losing information and, if so, shifts it.
//  Ports    : work_in     - current working value
//             k           - stage shift distance (16, 8, 4, 2 or 1)
//             signed_mode - 0: leading-zero test, 1: redundant-sign test
//             work_out    - working value after this stage
//             take        - 1 when the shift by k was applied
//  Revision : 1.0 - initial release
// ============================================================================
module normalize_stage
    import seq_normalizer_pkg::*;
(
    input  logic [DATA_W-1:0] work_in,
    input  logic [AMT_W-1:0]  k,
    input  logic              signed_mode,
    output logic [DATA_W-1:0] work_out,
    output logic              take
);

    logic [DATA_W-1:0] w_test;
    logic [5:0]        w_low_bit;

    always_comb begin
        // In signed mode, XOR with the left-shifted value: bit i is zero
        // exactly when bits i and i-1 match, so "top k+1 bits all equal"
        // becomes "top k bits of w_test all zero" -- same test as unsigned.
        w_test    = signed_mode ? (work_in ^ {work_in[DATA_W-2:0], 1'b0}) : work_in;
        w_low_bit = 6'(DATA_W) - {1'b0, k};
        take      = ((w_test >> w_low_bit) == '0);
        work_out  = take ? (work_in << k) : work_in;
    end

endmodule : normalize_stage
`default_nettype wire

// File: rtl/seq_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : seq_normalizer
//  Purpose  : Multi-cycle normalizer. Finds the left shift that removes
//             leading zeros (unsigned) or redundant sign bits (signed) with a
//             5-step binary search (16,8,4,2,1), one step per clock, using a
//             single time-multiplexed normalize_stage.
//  Ports    : CLK, RST        - clock, synchronous active-high reset
//             START           - request, sampled only in IDLE
//             SIGNED_MODE     - 0 leading zeros, 1 redundant sign bits
//             D_IN[31:0]      - operand, captured with START
//             BUSY            - operation in progress
//             DONE            - one-cycle result-valid pulse
//             D_OUT[31:0]     - normalized operand
//             SH_AMT[4:0]     - applied left-shift distance
//             ALL_FILL        - operand was all fill bits
//  Revision : 1.0 - initial release
// ============================================================================
module seq_normalizer
    import seq_normalizer_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              SIGNED_MODE,
    input  logic [DATA_W-1:0] D_IN,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] D_OUT,
    output logic [AMT_W-1:0]  SH_AMT,
    output logic              ALL_FILL
);

    state_t            r_state;
    state_t            w_state_next;

    logic [DATA_W-1:0] r_work;
    logic [AMT_W-1:0]  r_amt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_signed;
    logic              r_fill_cap;
    logic              r_all_fill;
    logic              r_done;

    logic [AMT_W-1:0]  w_k;
    logic [DATA_W-1:0] w_stage_out;
    logic              w_take;
    logic              w_fill_in;

    // Stage distance is 2**counter; the same one-hot value is also the
    // SH_AMT bit that the stage contributes.
    assign w_k       = AMT_W'(1) << r_cnt;
    assign w_fill_in = (D_IN == '0) || (SIGNED_MODE && (D_IN == '1));

    normalize_stage u_stage (
        .work_in     (r_work),
        .k           (w_k),
        .signed_mode (r_signed),
        .work_out    (w_stage_out),
        .take        (w_take)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        BUSY         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                BUSY = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                BUSY         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_work     <= '0;
            r_amt      <= '0;
            r_cnt      <= '0;
            r_signed   <= 1'b0;
            r_fill_cap <= 1'b0;
            r_all_fill <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // DONE is the registered image of the DONE state, so the pulse
            // lands in the IDLE cycle and a new START can be taken there.
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_work     <= D_IN;
                        r_signed   <= SIGNED_MODE;
                        r_amt      <= '0;
                        r_all_fill <= 1'b0;
                        r_cnt      <= CNT_W'(N_STAGES - 1);
                        r_fill_cap <= w_fill_in;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_stage_out;
                    r_amt  <= r_amt | (w_take ? w_k : '0);
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_all_fill <= r_fill_cap;
                end
                default: begin
                end
            endcase
        end
    end

    assign DONE     = r_done;
    assign D_OUT    = r_work;
    assign SH_AMT   = r_amt;
    assign ALL_FILL = r_all_fill;

endmodule : seq_normalizer
`default_nettype wire
